himax_strobe_ctrl: RTL

Frame-level controller that drives the IR LED strobe stage of the Himax camera pipeline. On every frame boundary it decides whether the next frame is lit and whether the strobe runs in search or full mode. It produces `o_strobe_req` and `o_search` for the LED strobe timer, and `o_lit_frame` for downstream lit/dark background subtraction. Inputs are the camera vertical sync and per-frame hand-detection results from the classifier.

---
 rtl/himax_strobe_ctrl_if.sv | 36 +++
 rtl/himax_strobe_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/himax_strobe_ctrl_if.sv
// -----------------------------------------------------------------------------
// himax_strobe_ctrl_if
//   Groups the signals between the frame-level strobe controller and its
//   surroundings. These are camera VS, enable, the classifier detection
//   results, the strobe/mode outputs, and a debug view of the FSM state.
//
//   Handshake: i_det_valid is a single-cycle qualifier with no ready/back-
//   pressure. A result is consumed in every cycle i_det_valid is high, and
//   i_det_hit is meaningful only in those cycles.
//
//   Modports
//     master : environment side (drives inputs, observes outputs)
//     slave  : controller side (himax_strobe_ctrl)
// -----------------------------------------------------------------------------
interface himax_strobe_ctrl_if;
   logic        i_vs;
   logic        i_enable;
   logic        i_det_valid;
   logic        i_det_hit;
   logic        o_strobe_req;
   logic        o_search;
   logic        o_lit_frame;
   logic [15:0] o_frame_cnt;
   logic        o_vs_lost;
   logic [1:0]  dbg_state;

   modport master (
      output i_vs, i_enable, i_det_valid, i_det_hit,
      input  o_strobe_req, o_search, o_lit_frame, o_frame_cnt, o_vs_lost, dbg_state
   );

   modport slave (
      input  i_vs, i_enable, i_det_valid, i_det_hit,
      output o_strobe_req, o_search, o_lit_frame, o_frame_cnt, o_vs_lost, dbg_state
   );
endinterface

// File: rtl/himax_strobe_ctrl.sv
// -----------------------------------------------------------------------------
// himax_strobe_ctrl
//   Frame-level IR strobe controller. On each VS falling edge (fe) it decides
//   whether the next frame period is lit (o_strobe_req), and whether the
//   strobe runs short/search or full (o_search). It also reports which
//   delivered frame was lit (o_lit_frame). Hand-detection results steer the
//   FSM between SEARCH and TRACK. A VS watchdog kills the strobe when frames
//   stop arriving.
//
//   Ports
//     clk     : system clock
//     resetn  : synchronous active-low reset
//     bus     : himax_strobe_ctrl_if.slave
//               in : i_vs (async), i_enable, i_det_valid, i_det_hit
//               out: o_strobe_req, o_search, o_lit_frame, o_frame_cnt[15:0],
//                    o_vs_lost, dbg_state[1:0] (0 IDLE, 1 SEARCH, 2 TRACK)
// -----------------------------------------------------------------------------
module himax_strobe_ctrl #(
   parameter logic [7:0]  HIT_LIMIT  = 8'd2,
   parameter logic [7:0]  MISS_LIMIT = 8'd8,
   parameter logic [23:0] VS_TIMEOUT = 24'd4_000_000
) (
   input  logic               clk,
   input  logic               resetn,
   himax_strobe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_TRACK  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  vs_q, vs_d;
   logic        phase_q, phase_d;
   logic [7:0]  hit_cnt_q, hit_cnt_d;
   logic [7:0]  miss_cnt_q, miss_cnt_d;
   logic [23:0] wd_q, wd_d;
   logic        strobe_req_q, strobe_req_d;
   logic        search_q, search_d;
   logic        lit_frame_q, lit_frame_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        vs_lost_q, vs_lost_d;

   logic        fe;
   logic        det_hit, det_miss;
   logic [7:0]  hit_cnt_n, miss_cnt_n;

   always_comb begin
      // The first two stages of vs_q also synchronise the asynchronous VS.
      // The edge uses the same taps as the downstream strobe timer so both
      // blocks see fe in the same cycle.
      vs_d = {vs_q[1:0], bus.i_vs};
      fe   = (vs_q[2:1] == 2'b10);

      det_hit  = bus.i_det_valid &  bus.i_det_hit;
      det_miss = bus.i_det_valid & ~bus.i_det_hit;

      // Counter values including a result landing in this very cycle, so a
      // result coincident with fe counts toward that boundary's decision.
      hit_cnt_n  = det_hit  ? ((hit_cnt_q  == 8'hFF) ? hit_cnt_q  : hit_cnt_q  + 8'd1)
                 : det_miss ? 8'd0 : hit_cnt_q;
      miss_cnt_n = det_miss ? ((miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1)
                 : det_hit  ? 8'd0 : miss_cnt_q;

      state_d = state_q;
      phase_d = phase_q;
      if (fe) begin
         if (!bus.i_enable) begin
            state_d = ST_IDLE;
         end else if (state_q == ST_IDLE) begin
            state_d = ST_SEARCH;
         end else if (state_q == ST_SEARCH && hit_cnt_n >= HIT_LIMIT) begin
            state_d = ST_TRACK;
         end else if (state_q == ST_TRACK && miss_cnt_n >= MISS_LIMIT) begin
            state_d = ST_SEARCH;
         end
         // Phase only runs while active; leaving IDLE always restarts it at 0.
         phase_d = (state_q == ST_IDLE) ? 1'b0 : ~phase_q;
      end

      hit_cnt_d  = hit_cnt_n;
      miss_cnt_d = miss_cnt_n;
      if (state_d != state_q || state_q == ST_IDLE) begin
         hit_cnt_d  = 8'd0;
         miss_cnt_d = 8'd0;
      end

      // Watchdog counts cycles since the last fe and parks at the limit.
      if (fe) begin
         wd_d = 24'd0;
      end else if (wd_q >= VS_TIMEOUT) begin
         wd_d = VS_TIMEOUT;
      end else begin
         wd_d = wd_q + 24'd1;
      end
      // On fe wd_d is 0, so the flag drops exactly at the recovering edge.
      vs_lost_d = (wd_d == VS_TIMEOUT);

      strobe_req_d = strobe_req_q;
      search_d     = search_q;
      lit_frame_d  = lit_frame_q;
      frame_cnt_d  = frame_cnt_q;
      if (fe) begin
         strobe_req_d = (state_d != ST_IDLE) & phase_d & ~vs_lost_d;
         search_d     = (state_d != ST_TRACK);
         // Delivered frame was exposed during the period that just ended.
         lit_frame_d  = strobe_req_q;
         if (bus.i_enable) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
      end else if (vs_lost_d) begin
         strobe_req_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         vs_q         <= 3'b111;
         phase_q      <= 1'b0;
         hit_cnt_q    <= 8'd0;
         miss_cnt_q   <= 8'd0;
         wd_q         <= 24'd0;
         strobe_req_q <= 1'b0;
         search_q     <= 1'b1;
         lit_frame_q  <= 1'b0;
         frame_cnt_q  <= 16'd0;
         vs_lost_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vs_q         <= vs_d;
         phase_q      <= phase_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         wd_q         <= wd_d;
         strobe_req_q <= strobe_req_d;
         search_q     <= search_d;
         lit_frame_q  <= lit_frame_d;
         frame_cnt_q  <= frame_cnt_d;
         vs_lost_q    <= vs_lost_d;
      end
   end

   assign bus.o_strobe_req = strobe_req_q;
   assign bus.o_search     = search_q;
   assign bus.o_lit_frame  = lit_frame_q;
   assign bus.o_frame_cnt  = frame_cnt_q;
   assign bus.o_vs_lost    = vs_lost_q;
   assign bus.dbg_state    = state_q;

endmodule
